// File: rtl/fir_tap_if.sv
// Tap stream from the FIR tap sequencer to a time-multiplexed MAC stage.
// One tap (all channels) moves per valid/ready handshake.
interface fir_tap_if #(
    parameter int unsigned DataWidth   = 16,
    parameter int unsigned NumTaps     = 5,
    parameter int unsigned NumChannels = 2
);
    localparam int unsigned IdxWidth = $clog2(NumTaps);

    logic [NumChannels-1:0][DataWidth-1:0] tap_data_o;
    logic [IdxWidth-1:0]                   tap_idx_o;
    logic                                  tap_valid_o;
    logic                                  tap_last_o;
    logic                                  tap_ready_i;

    modport master (
        output tap_data_o, tap_idx_o, tap_valid_o, tap_last_o,
        input  tap_ready_i
    );

    modport slave (
        input  tap_data_o, tap_idx_o, tap_valid_o, tap_last_o,
        output tap_ready_i
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Multi-channel FIR sample history: stores one sample per strobe edge, then
// streams the NumTaps most recent samples newest-first over a tap handshake.
module fir_tap_sequencer #(
    parameter int unsigned DataWidth   = 16,
    parameter int unsigned NumTaps     = 5,
    parameter int unsigned NumChannels = 2,
    parameter int unsigned AddrWidth   = $clog2(NumTaps)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  valid_strobe,
    input  logic [NumChannels-1:0][DataWidth-1:0] data_in,
    input  logic                                  flush_i,
    fir_tap_if.master                             tap,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  overrun_o
);
    localparam int unsigned IdxWidth  = $clog2(NumTaps);
    localparam int unsigned FillWidth = $clog2(NumTaps + 1);
    localparam int unsigned Depth     = 2 ** AddrWidth;

    typedef logic [NumChannels-1:0][DataWidth-1:0] sample_t;
    typedef enum logic {IDLE, READ} state_e;

    state_e               state_q, state_d;
    logic                 strobe_q;
    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [FillWidth-1:0] fill_q, fill_d;
    logic [IdxWidth-1:0]  idx_d;
    logic                 valid_d, last_d, busy_d, done_d, overrun_d;
    sample_t              data_d;
    sample_t              store_q [Depth];

    logic                 pos_edge_c;
    logic                 we_c;
    logic [IdxWidth-1:0]  idx_nxt_c;
    logic [AddrWidth-1:0] rd_addr_c;

    assign pos_edge_c = valid_strobe & ~strobe_q;
    assign idx_nxt_c  = tap.tap_idx_o + IdxWidth'(1);

    // Address of the next tap, wrapping modulo NumTaps like the write pointer
    always_comb begin
        rd_addr_c = '0;
        if (32'(wr_ptr_q) >= 32'(idx_nxt_c)) begin
            rd_addr_c = AddrWidth'(32'(wr_ptr_q) - 32'(idx_nxt_c));
        end else begin
            rd_addr_c = AddrWidth'(32'(wr_ptr_q) + NumTaps - 32'(idx_nxt_c));
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        idx_d     = tap.tap_idx_o;
        valid_d   = tap.tap_valid_o;
        data_d    = tap.tap_data_o;
        busy_d    = busy_o;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        we_c      = 1'b0;

        if (flush_i) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            fill_d   = '0;
            idx_d    = '0;
            valid_d  = 1'b0;
            data_d   = '0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pos_edge_c) begin
                        we_c    = 1'b1;
                        fill_d  = (32'(fill_q) == NumTaps) ? fill_q : fill_q + FillWidth'(1);
                        state_d = READ;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        data_d  = data_in;
                        busy_d  = 1'b1;
                    end
                end
                READ: begin
                    overrun_d = pos_edge_c;
                    if (tap.tap_valid_o && tap.tap_ready_i) begin
                        if (32'(tap.tap_idx_o) == NumTaps - 1) begin
                            state_d  = IDLE;
                            idx_d    = '0;
                            valid_d  = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            wr_ptr_d = (32'(wr_ptr_q) == NumTaps - 1) ? '0
                                                                      : wr_ptr_q + AddrWidth'(1);
                        end else begin
                            idx_d  = idx_nxt_c;
                            // History not yet written reads as zero
                            data_d = (32'(idx_nxt_c) < 32'(fill_q)) ? store_q[rd_addr_c] : '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        last_d = valid_d & (32'(idx_d) == NumTaps - 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            strobe_q        <= 1'b0;
            wr_ptr_q        <= '0;
            fill_q          <= '0;
            tap.tap_idx_o   <= '0;
            tap.tap_valid_o <= 1'b0;
            tap.tap_last_o  <= 1'b0;
            tap.tap_data_o  <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            state_q         <= state_d;
            strobe_q        <= valid_strobe;
            wr_ptr_q        <= wr_ptr_d;
            fill_q          <= fill_d;
            tap.tap_idx_o   <= idx_d;
            tap.tap_valid_o <= valid_d;
            tap.tap_last_o  <= last_d;
            tap.tap_data_o  <= data_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
            overrun_o       <= overrun_d;
        end
    end

    // Sample store; contents are masked by fill so it needs no reset
    always_ff @(posedge clk_i) begin
        if (we_c) begin
            store_q[wr_ptr_q] <= data_in;
        end
    end
endmodule
